// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the RV32I data-memory responder.
// Contents: Funct3 access encodings, FSM state constants, byte-enable width,
//           and a helper that derives byte enables from size and address.
package mem_pkg;

  // Funct3 encodings (instr[14:12]) for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // One enable bit per byte lane of a 32-bit word
  localparam int BE_W = 4;

  // FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Byte enables for an access; Funct3[1:0] is the size (byte/half/word).
  // Alignment has already been checked, so half accesses sit on lanes 0-1 or 2-3.
  function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-enabled word storage for the data-memory responder.
// Ports: clk; we/be/wdata write the word at idx on the rising edge (per-lane);
//        rdata is a combinational read of the word at idx.
module data_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [BE_W-1:0] be,
  input  logic [AW-1:0]   idx,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset; only enabled lanes are written
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the RV32I core: byte/half/word loads and stores
// against an internal array, with WAIT_STATES extra cycles per access.
// Ports: clk, reset (sync, active-low); MemRead/MemWrite/Funct3/Addr/WrData
//        request from the core; RdData (extended load, DONE only), Stall, AccErr.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        AccErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t      state;
  logic [3:0]  cnt;

  // Request captured in IDLE; the core holds its inputs while stalled, but the
  // commit in WAIT works from this copy so it never depends on that.
  logic          lat_wr;
  logic [2:0]    lat_f3;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wd;

  logic          req, size_ok, aligned, req_ok, idle;
  logic          op_wr, commit;
  logic [2:0]    op_f3;
  logic [AW+1:0] op_addr;
  logic [31:0]   op_wd, wdata_rep, rdata, shifted, load_ext;

  // Upper address bits alias onto the array and are intentionally dropped
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:AW+2];

  assign req  = MemRead | MemWrite;
  assign idle = (state == ST_IDLE);

  // Legality: MemWrite wins when both strobes are high, so the store table applies
  always_comb begin
    size_ok = 1'b0;
    if (MemWrite) size_ok = Funct3 inside {F3_SB, F3_SH, F3_SW};
    else          size_ok = Funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    aligned = 1'b1;
    case (Funct3[1:0])
      2'b01:   aligned = ~Addr[0];
      2'b10:   aligned = (Addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign req_ok = req & size_ok & aligned;
  assign Stall  = (idle & req_ok) | (state == ST_WAIT);
  assign AccErr = idle & req & ~req_ok;

  // With zero wait states the commit happens on the IDLE edge from live inputs
  assign op_wr   = idle ? MemWrite : lat_wr;
  assign op_f3   = idle ? Funct3 : lat_f3;
  assign op_addr = idle ? Addr[AW+1:0] : lat_addr;
  assign op_wd   = idle ? WrData : lat_wd;

  assign commit = (idle & req_ok & (WAIT_STATES == 0)) |
                  ((state == ST_WAIT) & (cnt == 4'd0));

  // Replicate store data so whichever lanes are enabled see the right byte(s)
  always_comb begin
    case (op_f3[1:0])
      2'b00:   wdata_rep = {4{op_wd[7:0]}};
      2'b01:   wdata_rep = {2{op_wd[15:0]}};
      default: wdata_rep = op_wd;
    endcase
  end

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    // reset gating keeps a store that is cut off mid-access from landing
    .we    (commit & op_wr & reset),
    .be    (byte_en(op_f3, op_addr[1:0])),
    .idx   (op_addr[AW+1:2]),
    .wdata (wdata_rep),
    .rdata (rdata)
  );

  // Lane select then extend; half accesses are aligned so a 0/16 shift suffices
  assign shifted = rdata >> {op_addr[1:0], 3'b000};

  always_comb begin
    case (op_f3)
      F3_LB:   load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_ext = rdata;
      F3_LBU:  load_ext = {24'd0, shifted[7:0]};
      F3_LHU:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      RdData <= 32'd0;
    end else begin
      // RdData is non-zero only for the single DONE cycle
      RdData <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            if (WAIT_STATES == 0) begin
              state <= ST_DONE;
              if (!MemWrite) RdData <= load_ext;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
            if (!lat_wr) RdData <= load_ext;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idle && req_ok) begin
      lat_wr   <= MemWrite;
      lat_f3   <= Funct3;
      lat_addr <= Addr[AW+1:0];
      lat_wd   <= WrData;
    end
  end

endmodule
